// File: rtl/jerky_sequencer.sv
// jerky_sequencer: streams the 1,2,1,4,1,8,... beat pattern over a
// valid/ready handshake under start/stop/step/clear control.
module jerky_sequencer #(
    parameter int WIDTH = 8,
    parameter int EW    = $clog2(WIDTH)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic             stop,
    input  logic             step,
    input  logic             clear,
    input  logic [EW-1:0]    cfg_max_exp,
    output logic [WIDTH-1:0] count,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             busy,
    output logic             wrap,
    output logic [EW:0]      index
);
    typedef enum logic [1:0] {IDLE, RUN, DRAIN, STEP} state_e;

    localparam logic [EW-1:0] E_MAX = EW'(WIDTH - 1);

    state_e           state_q, state_d;
    logic [EW:0]      idx_q, idx_d;
    logic [EW-1:0]    e_q, e_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic             valid_q, valid_d;
    logic             busy_q, busy_d;
    logic             wrap_q, wrap_d;
    logic             fire;
    logic             last;
    logic [EW-1:0]    cfg_e;

    function automatic logic [WIDTH-1:0] beat_of(input logic [EW:0] i);
        logic [EW:0] sh;
        sh = {1'b0, i[EW:1]} + (EW+1)'(1);
        return i[0] ? (WIDTH'(1) << sh) : WIDTH'(1);
    endfunction

    always_comb begin
        int unsigned raw;
        raw   = 32'(cfg_max_exp);
        cfg_e = cfg_max_exp;
        if (raw == 0)
            cfg_e = EW'(1);
        else if (raw > WIDTH - 1)
            cfg_e = E_MAX;
    end

    assign fire = valid_q & out_ready;
    assign last = (idx_q == ({e_q, 1'b0} - (EW+1)'(1)));

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        e_d     = e_q;
        wrap_d  = 1'b0;
        if (fire) begin
            if (last) begin
                idx_d  = '0;
                wrap_d = 1'b1;
                e_d    = cfg_e;
            end else begin
                idx_d = idx_q + (EW+1)'(1);
            end
        end
        case (state_q)
            IDLE: begin
                // E may only follow cfg while parked at the start of a sequence
                if (idx_q == '0)
                    e_d = cfg_e;
                if (start)
                    state_d = RUN;
                else if (step)
                    state_d = STEP;
                else if (clear)
                    idx_d = '0;
            end
            RUN: begin
                if (stop)
                    state_d = fire ? IDLE : DRAIN;
            end
            DRAIN, STEP: begin
                if (fire)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        valid_d = (state_d != IDLE);
        busy_d  = (state_d != IDLE);
        count_d = beat_of(idx_d);
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q <= IDLE;
            idx_q   <= '0;
            e_q     <= E_MAX;
            count_q <= WIDTH'(1);
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            wrap_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            e_q     <= e_d;
            count_q <= count_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            wrap_q  <= wrap_d;
        end
    end

    assign count     = count_q;
    assign out_valid = valid_q;
    assign busy      = busy_q;
    assign wrap      = wrap_q;
    assign index     = idx_q;
endmodule

// File: tb/tb_jerky_sequencer.sv
// Scoreboard bench for jerky_sequencer: a transaction-level model predicts
// every accepted beat; a negedge monitor pops and compares on each fire.
module tb_jerky_sequencer;
    localparam int W  = 8;
    localparam int EWT = $clog2(W);

    logic           clock;
    logic           reset;
    logic           start, stop, step, clear;
    logic [EWT-1:0] cfg_max_exp;
    logic [W-1:0]   count;
    logic           out_valid, out_ready;
    logic           busy, wrap;
    logic [EWT:0]   index;

    jerky_sequencer #(.WIDTH(W)) dut (
        .clock(clock), .reset(reset), .start(start), .stop(stop),
        .step(step), .clear(clear), .cfg_max_exp(cfg_max_exp),
        .count(count), .out_valid(out_valid), .out_ready(out_ready),
        .busy(busy), .wrap(wrap), .index(index)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        int unsigned val;
        int unsigned idx;
        bit          wr;
    } beat_t;

    beat_t sb[$];
    int    n_chk = 0;
    int    n_err = 0;

    // reference model state: next beat position, active and pending exponent
    int unsigned m_idx;
    int unsigned m_e;
    int unsigned m_cfg;
    bit          m_idle;

    task automatic chk(input string name, input longint unsigned act,
                       input longint unsigned exp);
        n_chk++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int unsigned clamp(input int unsigned v);
        if (v == 0) return 1;
        if (v > W - 1) return W - 1;
        return v;
    endfunction

    task automatic idle_sync();
        m_idle = 1'b1;
        if (m_idx == 0) m_e = m_cfg;
    endtask

    task automatic set_cfg(input int unsigned v);
        cfg_max_exp = EWT'(v);
        m_cfg = clamp(v);
        if (m_idle && m_idx == 0) m_e = m_cfg;
    endtask

    task automatic push_beats(input int n);
        beat_t b;
        for (int k = 0; k < n; k++) begin
            b.idx = m_idx;
            b.val = (m_idx % 2 == 0) ? 1 : (1 << (m_idx / 2 + 1));
            b.wr  = (m_idx == 2 * m_e - 1);
            sb.push_back(b);
            if (b.wr) begin
                m_idx = 0;
                m_e   = m_cfg;
            end else begin
                m_idx++;
            end
        end
    endtask

    // run until n beats fire; leaves DUT in RUN holding the next beat
    task automatic drive_run(input int n, input bit rnd);
        int rem;
        int cyc;
        rem = n;
        cyc = 0;
        m_idle = 1'b0;
        start = 1'b1;
        stop = 1'b0;
        step = 1'b0;
        clear = 1'b0;
        while (rem > 0 && cyc < 40 * n + 20) begin
            out_ready = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
            if (out_valid && out_ready) rem--;
            @(posedge clock); #1;
            cyc++;
        end
        out_ready = 1'b0;
        chk("run_beats_left", rem, 0);
    endtask

    task automatic stop_drain(input int hold);
        push_beats(1);
        start = 1'b0;
        stop = 1'b1;
        out_ready = 1'b0;
        for (int h = 0; h < hold; h++) begin
            @(posedge clock); #1;
            chk("drain_valid", out_valid, 1);
            chk("drain_busy", busy, 1);
            start = 1'($urandom_range(0, 1));
            stop = 1'($urandom_range(0, 1));
        end
        out_ready = 1'b1;
        start = 1'($urandom_range(0, 1));
        if (hold == 0) stop = 1'b1;
        @(posedge clock); #1;
        out_ready = 1'b0;
        start = 1'b0;
        stop = 1'b0;
        chk("stopped_valid", out_valid, 0);
        chk("stopped_busy", busy, 0);
        chk("stopped_index", index, m_idx);
        idle_sync();
    endtask

    task automatic do_clear();
        clear = 1'b1;
        @(posedge clock); #1;
        clear = 1'b0;
        chk("clear_index", index, 0);
        chk("clear_count", count, 1);
        m_idx = 0;
        idle_sync();
    endtask

    // monitor: pops on every fire, checks wrap and stall stability
    bit          mon_en = 1'b0;
    bit          pend_wrap = 1'b0;
    bit          hold_f = 1'b0;
    int unsigned hold_cnt, hold_idx;
    beat_t       mb;

    always @(negedge clock) begin
        if (!mon_en) begin
            pend_wrap = 1'b0;
            hold_f = 1'b0;
        end else begin
            chk("wrap", wrap, pend_wrap);
            if (hold_f) begin
                chk("stall_valid", out_valid, 1);
                chk("stall_count", count, hold_cnt);
                chk("stall_index", index, hold_idx);
            end
            pend_wrap = 1'b0;
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    chk("unexpected_beat", count, 0);
                    n_err += (count == 0) ? 1 : 0;
                end else begin
                    mb = sb.pop_front();
                    chk("beat_count", count, mb.val);
                    chk("beat_index", index, mb.idx);
                    pend_wrap = mb.wr;
                end
            end
            hold_f = out_valid && !out_ready;
            hold_cnt = count;
            hold_idx = index;
        end
    end

    initial begin
        reset = 1'b0;
        start = 1'b0;
        stop = 1'b0;
        step = 1'b0;
        clear = 1'b0;
        out_ready = 1'b0;
        cfg_max_exp = EWT'(7);
        m_idx = 0;
        m_e = W - 1;
        m_cfg = 7;
        m_idle = 1'b1;

        repeat (2) @(posedge clock);
        #1;
        chk("rst_count", count, 1);
        chk("rst_valid", out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_wrap", wrap, 0);
        chk("rst_index", index, 0);
        reset = 1'b1;
        mon_en = 1'b1;

        // full E=7 period plus two beats, no backpressure
        push_beats(16);
        drive_run(16, 1'b0);
        stop_drain(2);

        // held beat of value 4 for three stalled cycles
        push_beats(1);
        start = 1'b1;
        @(posedge clock); #1;
        for (int k = 0; k < 4; k++) begin
            chk("bp_valid", out_valid, 1);
            chk("bp_count", count, 4);
            chk("bp_index", index, 3);
            if (k < 3) begin
                @(posedge clock); #1;
            end
        end
        out_ready = 1'b1;
        @(posedge clock); #1;
        out_ready = 1'b0;
        chk("bp_next_count", count, 1);
        chk("bp_next_index", index, 4);
        m_idle = 1'b0;
        stop_drain(0);

        // single steps from index 0
        do_clear();
        for (int s = 0; s < 3; s++) begin
            push_beats(1);
            m_idle = 1'b0;
            step = 1'b1;
            @(posedge clock); #1;
            step = 1'b0;
            chk("step_valid", out_valid, 1);
            chk("step_busy", busy, 1);
            out_ready = 1'b1;
            @(posedge clock); #1;
            out_ready = 1'b0;
            chk("step_done_valid", out_valid, 0);
            idle_sync();
        end

        // short sequence, then cfg change mid-run
        do_clear();
        set_cfg(2);
        push_beats(12);
        drive_run(12, 1'b1);
        set_cfg(0);
        push_beats(10);
        drive_run(10, 1'b1);
        stop_drain(1);

        for (int r = 0; r < 8; r++) begin
            int n;
            if ($urandom_range(0, 2) == 0) do_clear();
            set_cfg($urandom_range(0, 7));
            n = $urandom_range(1, 25);
            push_beats(n);
            drive_run(n, 1'b1);
            stop_drain($urandom_range(0, 2));
        end

        // reset mid-run while holding the 16 beat
        do_clear();
        set_cfg(7);
        push_beats(7);
        drive_run(7, 1'b0);
        @(posedge clock); #1;
        chk("pre_rst_count", count, 16);
        chk("pre_rst_sb_empty", sb.size(), 0);
        mon_en = 1'b0;
        reset = 1'b0;
        #2;
        chk("async_hold_count", count, 16);
        chk("async_hold_valid", out_valid, 1);
        @(posedge clock); #1;
        chk("mid_rst_count", count, 1);
        chk("mid_rst_valid", out_valid, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_wrap", wrap, 0);
        chk("mid_rst_index", index, 0);
        reset = 1'b1;
        start = 1'b0;
        sb.delete();
        m_idx = 0;
        m_e = W - 1;
        idle_sync();
        mon_en = 1'b1;

        set_cfg(0);
        push_beats(6);
        drive_run(6, 1'b1);
        stop_drain(1);
        repeat (3) @(posedge clock);
        #1;
        chk("sb_drained", sb.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
